// File: rtl/blade_ignition_seq_if.sv
// Request/length inputs and ramped-blade outputs of the blade ignition sequencer.
// The master drives the request side; the slave (the sequencer) drives the blade side.
interface blade_ignition_seq_if;
  logic       on_i;
  logic [1:0] len_ft_i;
  logic [5:0] len_dec_i;
  logic       pwr_warn_i;
  logic [8:0] blade_len_o;
  logic [1:0] blade_ft_o;
  logic [6:0] blade_dec_o;
  logic [1:0] state_o;
  logic       ignite_done_o;
  logic       retract_done_o;

  modport master (
    output on_i, len_ft_i, len_dec_i, pwr_warn_i,
    input  blade_len_o, blade_ft_o, blade_dec_o, state_o,
           ignite_done_o, retract_done_o
  );

  modport slave (
    input  on_i, len_ft_i, len_dec_i, pwr_warn_i,
    output blade_len_o, blade_ft_o, blade_dec_o, state_o,
           ignite_done_o, retract_done_o
  );
endinterface

// File: rtl/blade_ignition_seq.sv
// Ramps the blade length toward the configured target while lit and back to zero on
// switch-off or power warning; emits state and one-cycle completion pulses.
module blade_ignition_seq #(
  parameter int STEP     = 10,
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  blade_ignition_seq_if.slave bus
);
  localparam logic [1:0] S_OFF     = 2'd0;
  localparam logic [1:0] S_IGNITE  = 2'd1;
  localparam logic [1:0] S_ON      = 2'd2;
  localparam logic [1:0] S_RETRACT = 2'd3;

  localparam int              DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [8:0]       STEP_9   = 9'(STEP);

  logic [1:0]       state_q, state_d;
  logic [8:0]       len_q, len_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             ign_q, ign_d;
  logic             ret_q, ret_d;

  logic       run, tick;
  logic [8:0] target;
  logic [9:0] len_up;
  logic [8:0] up_sat, down_sat, retract_len;
  logic [8:0] gap;

  assign run    = bus.on_i & ~bus.pwr_warn_i;
  assign tick   = (div_q == DIV_LAST);
  assign target = 9'(bus.len_ft_i) * 9'd100 + 9'(bus.len_dec_i);

  // Saturating step helpers; the 10-bit sum keeps len+STEP from wrapping above 363.
  assign len_up      = {1'b0, len_q} + {1'b0, STEP_9};
  assign up_sat      = (len_up >= {1'b0, target}) ? target : len_up[8:0];
  assign gap         = len_q - target;
  assign down_sat    = (gap > STEP_9) ? (len_q - STEP_9) : target;
  assign retract_len = (len_q <= STEP_9) ? 9'd0 : (len_q - STEP_9);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    ign_d   = 1'b0;
    ret_d   = 1'b0;
    case (state_q)
      S_OFF: begin
        len_d = 9'd0;
        if (run) state_d = S_IGNITE;
      end
      S_IGNITE: begin
        if (!run) begin
          state_d = S_RETRACT;
        end else if (len_q >= target) begin
          state_d = S_ON;
          ign_d   = 1'b1;
        end else if (tick) begin
          len_d = up_sat;
          if (up_sat == target) begin
            state_d = S_ON;
            ign_d   = 1'b1;
          end
        end
      end
      S_ON: begin
        if (!run) begin
          state_d = S_RETRACT;
        end else if (tick) begin
          if (len_q < target)      len_d = up_sat;
          else if (len_q > target) len_d = down_sat;
        end
      end
      default: begin
        // Re-ignition resumes from the current length rather than restarting at zero.
        if (run) begin
          state_d = S_IGNITE;
        end else if (len_q == 9'd0) begin
          state_d = S_OFF;
          ret_d   = 1'b1;
        end else if (tick) begin
          len_d = retract_len;
          if (retract_len == 9'd0) begin
            state_d = S_OFF;
            ret_d   = 1'b1;
          end
        end
      end
    endcase
  end

  always_comb begin
    div_d = div_q + DIV_W'(1);
    if (state_q == S_OFF || state_d != state_q || tick) div_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_OFF;
      len_q   <= 9'd0;
      div_q   <= '0;
      ign_q   <= 1'b0;
      ret_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      div_q   <= div_d;
      ign_q   <= ign_d;
      ret_q   <= ret_d;
    end
  end

  // Feet/hundredths split by range compare instead of a divider.
  always_comb begin
    bus.blade_ft_o  = 2'd0;
    bus.blade_dec_o = 7'(len_q);
    if (len_q >= 9'd300) begin
      bus.blade_ft_o  = 2'd3;
      bus.blade_dec_o = 7'(len_q - 9'd300);
    end else if (len_q >= 9'd200) begin
      bus.blade_ft_o  = 2'd2;
      bus.blade_dec_o = 7'(len_q - 9'd200);
    end else if (len_q >= 9'd100) begin
      bus.blade_ft_o  = 2'd1;
      bus.blade_dec_o = 7'(len_q - 9'd100);
    end
  end

  assign bus.blade_len_o    = len_q;
  assign bus.state_o        = state_q;
  assign bus.ignite_done_o  = ign_q;
  assign bus.retract_done_o = ret_q;
endmodule

// File: tb/tb_blade_ignition_seq.sv
// Scoreboard bench: stimulus pushes the reference model's expected outputs per edge,
// an independent monitor pops and compares them just after each rising edge.
module tb_blade_ignition_seq;
  localparam int STEP     = 10;
  localparam int TICK_DIV = 4;
  localparam int M_OFF = 0, M_IGN = 1, M_ON = 2, M_RET = 3;

  typedef struct packed {
    logic [8:0] len;
    logic [1:0] ft;
    logic [6:0] dec;
    logic [1:0] st;
    logic       ign;
    logic       ret;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  int m_st, m_len, m_ph;

  blade_ignition_seq_if bus();

  blade_ignition_seq #(.STEP(STEP), .TICK_DIV(TICK_DIV)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic exp_t make_exp(input int st, input int len, input bit ign, input bit ret);
    exp_t e;
    e.len = 9'(len);
    e.ft  = 2'(len / 100);
    e.dec = 7'(len % 100);
    e.st  = 2'(st);
    e.ign = ign;
    e.ret = ret;
    return e;
  endfunction

  // Rules-level model of one clock edge: ticks fall on every TICK_DIV-th edge of a phase.
  task automatic model_step(input bit on, input bit warn, input int tgt);
    bit run, tick, ign, ret;
    int ns, nl;
    run  = on && !warn;
    tick = (m_st != M_OFF) && ((m_ph % TICK_DIV) == TICK_DIV - 1);
    ns = m_st; nl = m_len; ign = 0; ret = 0;
    case (m_st)
      M_OFF: begin nl = 0; if (run) ns = M_IGN; end
      M_IGN: begin
        if (!run) ns = M_RET;
        else if (m_len >= tgt) begin ns = M_ON; ign = 1; end
        else if (tick) begin
          nl = (m_len + STEP < tgt) ? m_len + STEP : tgt;
          if (nl == tgt) begin ns = M_ON; ign = 1; end
        end
      end
      M_ON: begin
        if (!run) ns = M_RET;
        else if (tick) begin
          if (m_len < tgt) nl = (m_len + STEP < tgt) ? m_len + STEP : tgt;
          else             nl = (m_len - STEP > tgt) ? m_len - STEP : tgt;
        end
      end
      default: begin
        if (run) ns = M_IGN;
        else if (m_len == 0) begin ns = M_OFF; ret = 1; end
        else if (tick) begin
          nl = (m_len - STEP > 0) ? m_len - STEP : 0;
          if (nl == 0) begin ns = M_OFF; ret = 1; end
        end
      end
    endcase
    m_ph  = (ns != m_st || ns == M_OFF) ? 0 : m_ph + 1;
    m_st  = ns;
    m_len = nl;
    exp_q.push_back(make_exp(m_st, m_len, ign, ret));
  endtask

  task automatic run_cycles(input int n, input bit on, input bit warn, input int ft, input int dec);
    repeat (n) begin
      @(negedge clk);
      rst            = 1'b1;
      bus.on_i       = on;
      bus.pwr_warn_i = warn;
      bus.len_ft_i   = 2'(ft);
      bus.len_dec_i  = 6'(dec);
      model_step(on, warn, ft * 100 + dec);
    end
  endtask

  task automatic do_reset(input int n);
    exp_t act;
    @(negedge clk);
    rst = 1'b0;
    #1;
    act = {bus.blade_len_o, bus.blade_ft_o, bus.blade_dec_o, bus.state_o,
           bus.ignite_done_o, bus.retract_done_o};
    checks++;
    if (act !== '0) begin
      errors++;
      $display("FAIL async_reset actual=%h required=0", act);
    end
    m_st = M_OFF; m_len = 0; m_ph = 0;
    exp_q.push_back(make_exp(M_OFF, 0, 0, 0));
    repeat (n - 1) begin
      @(negedge clk);
      exp_q.push_back(make_exp(M_OFF, 0, 0, 0));
    end
  endtask

  initial begin : monitor
    exp_t e, act;
    forever begin
      @(posedge clk);
      #1;
      act = {bus.blade_len_o, bus.blade_ft_o, bus.blade_dec_o, bus.state_o,
             bus.ignite_done_o, bus.retract_done_o};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty at %0t actual len=%0d state=%0d", $time,
                 act.len, act.st);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          errors++;
          $display("FAIL edge_%0t actual len=%0d ft=%0d dec=%0d st=%0d ign=%b ret=%b required len=%0d ft=%0d dec=%0d st=%0d ign=%b ret=%b",
                   $time, act.len, act.ft, act.dec, act.st, act.ign, act.ret,
                   e.len, e.ft, e.dec, e.st, e.ign, e.ret);
        end
      end
    end
  end

  initial begin : stimulus
    rst = 1'b0;
    bus.on_i = 1'b0; bus.pwr_warn_i = 1'b0; bus.len_ft_i = 2'd0; bus.len_dec_i = 6'd0;
    m_st = M_OFF; m_len = 0; m_ph = 0;
    exp_q.push_back(make_exp(M_OFF, 0, 0, 0));
    repeat (2) begin
      @(negedge clk);
      exp_q.push_back(make_exp(M_OFF, 0, 0, 0));
    end
    // Directed walk through the ignition scenarios.
    run_cycles(62, 1, 0, 1, 50);   // ignite to 150
    run_cycles(45, 1, 0, 2, 33);   // grow to 233
    run_cycles(45, 1, 0, 1, 50);   // shrink back to 150
    run_cycles(29, 0, 0, 1, 50);   // retract to 80
    run_cycles(40, 1, 0, 1, 50);   // resume to 150
    run_cycles(70, 0, 0, 1, 50);   // full retract
    run_cycles(29, 1, 0, 1, 50);   // ignite to 70
    run_cycles(45, 1, 1, 1, 50);   // power warning retract, blocked
    run_cycles(5,  1, 0, 0, 0);    // zero target
    run_cycles(160, 1, 0, 3, 63);  // maximum length 363
    run_cycles(20, 0, 0, 3, 63);
    do_reset(3);                   // reset mid-retract
    run_cycles(20, 1, 0, 2, 10);
    do_reset(2);
    // Randomized segments.
    for (int s = 0; s < 80; s++) begin
      if ($urandom_range(0, 19) == 0) begin
        do_reset(int'($urandom_range(1, 3)));
      end else begin
        run_cycles(int'($urandom_range(1, 50)), $urandom_range(0, 3) != 0,
                   $urandom_range(0, 7) == 0, int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 63)));
      end
    end
    @(posedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/blade_ignition_seq.md
Name: blade_ignition_seq

Overview:
- Downstream of the on/off and length registers; upstream of the blade display/emitter driver.
- Turns the registered on/off request and the configured length (feet + hundredths) into a time-ramped blade length.
- The blade extends gradually on ignition, tracks length changes while lit, and retracts gradually on switch-off or power warning.
- Emits state and one-cycle completion pulses for the power and sound logic.

Parameters:
- STEP, 10, hundredths of a foot added/removed per tick (1..63)
- TICK_DIV, 4, clocks per ramp tick (>=1)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-low reset (0 = reset)
- on_i  in  1  registered on/off request
- len_ft_i  in  2  configured length, whole feet (0..3)
- len_dec_i  in  6  configured length, hundredths of a foot (0..63)
- pwr_warn_i  in  1  low-power warning from the power block
- blade_len_o  out  9  current extended length, hundredths of a foot (0..363)
- blade_ft_o  out  2  blade_len_o / 100
- blade_dec_o  out  7  blade_len_o % 100
- state_o  out  2  0=OFF, 1=IGNITE, 2=ON, 3=RETRACT
- ignite_done_o  out  1  one-cycle pulse when IGNITE completes
- retract_done_o  out  1  one-cycle pulse when RETRACT reaches 0

Behaviour:
- Reset (rst=0, async):
  - state=OFF; blade_len=0; divider=0.
  - Both pulses 0.
  - All outputs 0 until the first clock after release.
- Target length:
  - target = len_ft_i*100 + len_dec_i, combinational, 9-bit, max 363.
  - The target is not latched, so input changes take effect on the next edge.
- run = on_i & ~pwr_warn_i.
- Divider:
  - Counts 0..TICK_DIV-1 and wraps.
  - Held at 0 in OFF; cleared to 0 on every state change.
  - tick = (divider == TICK_DIV-1).
- OFF:
  - blade_len held at 0.
  - If run, go to IGNITE on the next edge; otherwise stay in OFF.
- IGNITE:
  - Abort priority: if ~run, go to RETRACT; blade_len is unchanged.
  - Else if blade_len >= target: go to ON with blade_len unchanged, and pulse ignite_done_o. This covers target=0, which gives a 1-cycle IGNITE.
  - Else, on tick: blade_len = min(blade_len+STEP, target). If the result equals target, go to ON on the same edge and pulse ignite_done_o.
- ON:
  - If ~run, go to RETRACT.
  - Else, on tick, step toward target by STEP, saturating exactly at target, in either direction.
  - blade_len == target means hold.
- RETRACT:
  - If run, go to IGNITE and resume from the current blade_len (no jump).
  - Else, on tick: blade_len = max(blade_len-STEP, 0). If the result is 0, go to OFF and pulse retract_done_o.
  - If entered with blade_len=0, go to OFF on the next edge with retract_done_o.
- Pulses: registered, high for exactly the one cycle following the transition edge; never both high together.
- Simultaneous events:
  - pwr_warn_i overrides on_i.
  - An abort in IGNITE/ON takes priority over a tick on the same edge, so blade_len is not updated on that edge.
- Decode: blade_ft_o/blade_dec_o come from combinational compares against 100/200/300. blade_dec_o can reach 99 mid-ramp.
- Reset mid-ramp immediately forces OFF / length 0, with no retract pulse.

Test Plan:
- Basic ignite/retract (STEP=10, TICK_DIV=4, 1 ft 50):
  - Stimulus: rst released; on_i=1; len=1 ft 50.
  - IGNITE the cycle after sampling; blade_len 10 at edge 4, ..., 150 at edge 60.
  - state=ON, ignite_done_o high one cycle, blade_ft_o=1, blade_dec_o=50.
- Length change while ON:
  - Stimulus: from ON at 150, change len to 2 ft 33.
  - Ramps +10 per 4 clocks to 230, then saturates at 233 on the 9th tick.
  - Stays ON; no ignite_done_o pulse.
- Switch-off:
  - Stimulus: on_i=0 while ON at 150.
  - RETRACT; blade_len 140, 130, ..., 0 on edge 60.
  - state=OFF; retract_done_o pulses once.
- Power warning:
  - Stimulus: pwr_warn_i=1 with on_i=1 mid-IGNITE at blade_len=70.
  - RETRACT on the next edge; ramps down to 0.
  - Re-ignition is blocked while the warning stays high.
- Re-ignite and reset:
  - Stimulus: on_i 0→1 during RETRACT at 80.
  - IGNITE resumes from 80; reaches 150 after 7 ticks.
  - rst=0 mid-ramp forces OFF and 0 asynchronously, with no pulses.
- Edge cases:
  - target=0 with on_i=1: IGNITE→ON after 1 cycle, blade_len=0, ignite_done_o pulses.
  - Max length 3 ft 63 gives 363, blade_ft_o=3, blade_dec_o=63.
